// File: rtl/multiplicacion_secuencial_pkg.sv
// Shared definitions for the sequential arithmetic set. The controller
// states are reused by the sequential divider.
package multiplicacion_secuencial_pkg;

  // Operand width used when no override is given.
  localparam int DEFAULT_N = 4;

  // Controller states shared by the iterative multiplier and divider.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of an iteration counter that must reach n without wrapping.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/multiplicacion_secuencial_if.sv
// Request/result bundle of the sequential multiplier.
//
// Handshake: start is a request that the multiplier accepts on a rising
// edge only when it is not busy (IDLE or DONE). The operands are sampled
// on that same edge and are don't-care otherwise. busy is high for
// the N iteration cycles that follow. done is a one-cycle pulse, and
// producto is valid in that cycle and holds until the next accepted start.
// A start presented in the done cycle is accepted, so results can be
// issued back to back.
interface multiplicacion_secuencial_if #(
  parameter int N = 4
);

  logic           start;
  logic [N-1:0]   multiplicando;
  logic [N-1:0]   multiplicador;
  logic [2*N-1:0] producto;
  logic           busy;
  logic           done;

  // Requester side: issues operands, observes the result.
  modport master (
    output start,
    output multiplicando,
    output multiplicador,
    input  producto,
    input  busy,
    input  done
  );

  // Multiplier side.
  modport slave (
    input  start,
    input  multiplicando,
    input  multiplicador,
    output producto,
    output busy,
    output done
  );

endinterface

// File: rtl/multiplicacion_secuencial_sumador_n.sv
// (N+1)-bit combinational adder: partial product accumulator A plus the
// zero-extended multiplicand. A[N] is always clear before the add, so
// the sum never exceeds N+1 bits.
module sumador_n #(
  parameter int N = 4
) (
  input  logic [N:0]   a,
  input  logic [N-1:0] b,
  output logic [N:0]   suma
);

  // Carry of the N-bit add lands in suma[N].
  assign suma = a + {1'b0, b};

endmodule

// File: rtl/multiplicacion_secuencial.sv
// Sequential unsigned shift-add multiplier. One multiplier bit is retired
// per cycle; the 2N-bit product appears after N iterations.
module multiplicacion_secuencial
  import multiplicacion_secuencial_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic                         clk,
  input  logic                         rst,
  multiplicacion_secuencial_if.slave   bus,
  output state_t                       state_dbg
);

  localparam int CW = count_width(N);
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  state_t         state_q;
  state_t         state_d;

  logic [N-1:0]   m_q;
  logic [N:0]     a_q;
  logic [N-1:0]   q_q;
  logic [CW-1:0]  count_q;
  logic [2*N-1:0] producto_q;

  logic           load;
  logic           iterate;
  logic           finish;

  logic [N:0]     suma;
  logic [N:0]     addend;
  logic [N:0]     a_shift;
  logic [N-1:0]   q_shift;

  sumador_n #(
    .N (N)
  ) u_sumador (
    .a    (a_q),
    .b    (m_q),
    .suma (suma)
  );

  // Conditional add on the current multiplier LSB, then {A,Q} shifted
  // right by one as a single 2N+1-bit register with a zero entering A[N].
  always_comb begin
    addend  = q_q[0] ? suma : a_q;
    a_shift = {1'b0, addend[N:1]};
    q_shift = {addend[0], q_q[N-1:1]};
  end

  // Controller next state and datapath strobes.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    iterate = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        iterate = 1'b1;
        if (count_q == LAST_ITER) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state register; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture, shift-add iteration and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q        <= '0;
      a_q        <= '0;
      q_q        <= '0;
      count_q    <= '0;
      producto_q <= '0;
    end else begin
      if (load) begin
        m_q     <= bus.multiplicando;
        a_q     <= '0;
        q_q     <= bus.multiplicador;
        count_q <= '0;
      end else if (iterate) begin
        a_q     <= a_shift;
        q_q     <= q_shift;
        count_q <= count_q + CW'(1);
      end
      if (finish) begin
        producto_q <= {a_shift[N-1:0], q_shift};
      end
    end
  end

  assign bus.producto = producto_q;
  assign bus.busy     = (state_q == CALC);
  assign bus.done     = (state_q == DONE);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_multiplicacion_secuencial.sv
// Directed and randomized checks of the sequential multiplier at N=4 and N=8.
module tb_multiplicacion_secuencial;
  import multiplicacion_secuencial_pkg::*;

  logic   clk;
  logic   rst;
  state_t st4;
  state_t st8;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] exp_q[$];

  multiplicacion_secuencial_if #(.N(4)) b4 ();
  multiplicacion_secuencial_if #(.N(8)) b8 ();

  multiplicacion_secuencial #(.N(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .bus       (b4.slave),
    .state_dbg (st4)
  );

  multiplicacion_secuencial #(.N(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .bus       (b8.slave),
    .state_dbg (st8)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer product of the operands.
  function automatic logic [15:0] ref_mul(input int m, input int q);
    return 16'(m * q);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: present a start to the N=4 unit for one edge.
  task automatic start4(input int m, input int q);
    b4.start         = 1'b1;
    b4.multiplicando = 4'(m);
    b4.multiplicador = 4'(q);
    exp_q.push_back(ref_mul(m, q));
    step();
    b4.start         = 1'b0;
    b4.multiplicando = 4'($urandom_range(0, 15));
    b4.multiplicador = 4'($urandom_range(0, 15));
  endtask

  // Expect 4 busy cycles then a done pulse with the queued product.
  // With disturb set, start and operands are scrambled during CALC.
  task automatic wait_done4(input string tag, input bit disturb);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_busy"}, 64'(b4.busy), 64'd1);
      check({tag, "_nodone"}, 64'(b4.done), 64'd0);
      if (disturb) begin
        b4.start         = 1'($urandom_range(0, 1));
        b4.multiplicando = 4'($urandom_range(0, 15));
        b4.multiplicador = 4'($urandom_range(0, 15));
        if (i == 3) begin
          b4.start         = 1'b1;
          b4.multiplicando = 4'd1;
          b4.multiplicador = 4'd1;
        end
      end
      step();
    end
    check({tag, "_done"}, 64'(b4.done), 64'd1);
    check({tag, "_busy_off"}, 64'(b4.busy), 64'd0);
    check({tag, "_producto"}, 64'(b4.producto), 64'(exp_q.pop_front()));
    b4.start = 1'b0;
  endtask

  task automatic run8(input int m, input int q);
    logic [15:0] p;
    b8.start         = 1'b1;
    b8.multiplicando = 8'(m);
    b8.multiplicador = 8'(q);
    exp_q.push_back(ref_mul(m, q));
    step();
    b8.start = 1'b0;
    b8.multiplicando = 8'($urandom_range(0, 255));
    b8.multiplicador = 8'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++) begin
      check("n8_busy", 64'(b8.busy), 64'd1);
      step();
    end
    check("n8_done", 64'(b8.done), 64'd1);
    p = b8.producto;
    check("n8_producto", 64'(p), 64'(exp_q.pop_front()));
    if (m != 0) begin
      check("n8_div_resultado", 64'(int'(p) / m), 64'(q));
      check("n8_div_residuo", 64'(int'(p) % m), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    b4.start = 1'b0; b4.multiplicando = '0; b4.multiplicador = '0;
    b8.start = 1'b0; b8.multiplicando = '0; b8.multiplicador = '0;
    step(); step();
    rst = 1'b0;

    // Reset then idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      check("idle_producto", 64'(b4.producto), 64'd0);
      check("idle_busy", 64'(b4.busy), 64'd0);
      check("idle_done", 64'(b4.done), 64'd0);
      step();
    end
    check("idle_state", 64'(st4), 64'(IDLE));
    check("idle_n8_producto", 64'(b8.producto), 64'd0);

    // 13 x 11, then back to IDLE with the result held
    start4(13, 11);
    wait_done4("m13x11", 1'b0);
    step();
    check("after_done_busy", 64'(b4.busy), 64'd0);
    check("after_done_done", 64'(b4.done), 64'd0);
    check("after_done_state", 64'(st4), 64'(IDLE));
    check("after_done_hold", 64'(b4.producto), 64'd143);

    // Corners
    start4(15, 15);
    wait_done4("m15x15", 1'b0);
    step();
    start4(0, 9);
    wait_done4("m0x9", 1'b0);
    step();

    // Start and operands scrambled during CALC are ignored
    start4(6, 7);
    wait_done4("m6x7_disturb", 1'b1);
    step();
    check("disturb_idle", 64'(st4), 64'(IDLE));

    // Back-to-back: start 9x9 in the done cycle of 5x3
    start4(5, 3);
    wait_done4("m5x3", 1'b0);
    start4(9, 9);
    wait_done4("m9x9_b2b", 1'b0);
    step();

    // Reset during the second CALC cycle aborts with no done pulse
    b4.start = 1'b1; b4.multiplicando = 4'd12; b4.multiplicador = 4'd12;
    step();
    b4.start = 1'b0;
    check("abort_busy1", 64'(b4.busy), 64'd1);
    step();
    check("abort_busy2", 64'(b4.busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_state", 64'(st4), 64'(IDLE));
    check("abort_producto", 64'(b4.producto), 64'd0);
    check("abort_busy", 64'(b4.busy), 64'd0);
    for (int i = 0; i < 6; i++) begin
      check("abort_no_done", 64'(b4.done), 64'd0);
      step();
    end
    start4(12, 12);
    wait_done4("m12x12", 1'b0);
    step();

    // Reset wins over start in the same cycle
    rst = 1'b1; b4.start = 1'b1; b4.multiplicando = 4'd3; b4.multiplicador = 4'd3;
    step();
    rst = 1'b0; b4.start = 1'b0;
    check("rst_wins_state", 64'(st4), 64'(IDLE));
    check("rst_wins_busy", 64'(b4.busy), 64'd0);
    step();
    check("rst_wins_still_idle", 64'(b4.busy), 64'd0);

    // Randomized N=8 against the reference and the divider identity
    run8(255, 255);
    step();
    run8(0, 173);
    step();
    run8(1, 200);
    for (int i = 0; i < 25; i++) begin
      step();
      run8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end
    step();
    check("n8_end_idle", 64'(st8), 64'(IDLE));
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplicacion_secuencial.md
# multiplicacion_secuencial

Sequential unsigned shift-add multiplier, the inverse operation to the team's restoring divider in the Proyecto_2 arithmetic set. Takes two N-bit operands on a start pulse and produces a 2N-bit product after N iteration cycles, one multiplier bit per cycle. Supplies products to the ALU path and to self-checks of the divider (dividendo = divisor·resultado + residuo).

## Interface
- N, default 4: operand width; product is 2N bits; N ≥ 2.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- multiplicando  input  N  unsigned operand M; captured on accepted start.
- multiplicador  input  N  unsigned operand Q; captured on accepted start.
- producto  output  2N  unsigned product; holds last result until next accepted start.
- busy  output  1  high while iterating (CALC).
- done  output  1  one-cycle pulse; producto valid in that cycle.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: busy=0, done=0. start=1 → capture M, load A=0 (N+1 bits), Q=multiplicador, count=0; go CALC.
- CALC: busy=1. Per cycle: if Q[0]=1, A = A + {0,M} (N+1-bit add, carry kept in A[N]); then {A,Q} shifted right one bit as a 2N+1-bit quantity, A[N] ← 0. count increments; after N-th iteration go DONE.
- DONE: producto = {A[N-1:0], Q}, done=1, busy=0 for exactly one cycle. start=1 here is accepted (same capture as IDLE, go CALC); else go IDLE.
- start in CALC is ignored; operand inputs are don't-care except at accepted start.
- Operands are unsigned; no overflow possible (product < 2^(2N)).
- Captured operands are internal; changing inputs during CALC does not affect the result.

## Timing
- Reset (rst=1 at a rising edge): state=IDLE, producto=0, busy=0, done=0, A=0, Q=0, count=0. Reset wins over start in the same cycle.
- Reset during CALC aborts the operation; no done pulse; producto returns to 0.
- Latency: start accepted at edge k → busy=1 from k+1 for N cycles → done=1 and producto valid in cycle k+N+1.
- Throughput: back-to-back start in DONE cycle gives one result every N+1 cycles.
- producto is registered; updates only on the transition into DONE (and to 0 on reset).
- count width ⌈log2(N+1)⌉ bits; no wrap before reaching N.
- Zero operands still take full N cycles; no early termination.

## Structure
- Shared package: state typedef (IDLE, CALC, DONE) as an enum, reused by the team's future sequential divider.
- One natural sub-module: sumador_n, an (N+1)-bit combinational adder (A + {0,M}), parameterised by N; remaining control and shift registers stay in the top module.

## Test plan
- N=4, reset then idle: producto=0, busy=0, done=0 for 10 cycles with start=0.
- N=4, start with M=13, Q=11 at edge k: busy high k+1..k+4, done=1 in cycle k+5 with producto=143 (8'h8F), then IDLE.
- N=4, M=15, Q=15 → producto=225; M=0, Q=9 → producto=0 still after exactly 4 CALC cycles.
- N=4, M=6, Q=7 started; start pulsed with M=1, Q=1 during CALC and operand inputs toggled → ignored, producto=42.
- N=4, start in DONE cycle of 5×3 with 9×9 → first done shows 15, second done 5 cycles later shows 81.
- N=4, rst asserted in 2nd CALC cycle of 12×12 → next cycle IDLE, producto=0, no done pulse; subsequent 12×12 yields 144. Randomized N=8 run checks producto = M·Q against the divider: division(producto, M) gives resultado=Q, residuo=0 for M≠0.
